spi_controller_mc: RTL
======================

Name: spi_controller_mc

Overview:
Parametrised, multi-chip-select SPI controller and the next generation of the team's single-byte SPI controller. It generalises word width and chip-select count, supports all four SPI modes, selectable bit order and multi-word bursts with chip-select held asserted between words. It has an integrated SCLK divider and sits between a local device FSM and external SPI peripherals.

Parameters:
DATA_WIDTH, 8, bits per SPI word (>=2)
NUM_CS, 4, number of active-low chip selects (>=1)
DIV_WIDTH, 8, width of the SCLK half-period divider field
CS_W, $clog2(NUM_CS) (min 1), width of the CS select field (derived)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low; clock i_clk
i_cfg_div  in  DIV_WIDTH  SCLK half period = i_cfg_div+1 i_clk cycles
i_cfg_mode  in  2  SPI mode {CPOL,CPHA}
i_cfg_lsb_first  in  1  1 = LSB shifted first
i_cfg_cs_sel  in  CS_W  chip select index
i_cfg_valid  in  1  latch all i_cfg_* fields
i_tx  in  DATA_WIDTH  word to transmit
i_tx_last  in  1  1 = release CS after this word
i_tx_valid  in  1  start word (accepted only while o_ready=1)
o_rx  out  DATA_WIDTH  received word
o_rx_valid  out  1  one-cycle pulse, o_rx valid
i_cipo  in  1  serial data in
o_copi  out  1  serial data out
o_sclk  out  1  SPI clock
o_cs_n  out  NUM_CS  chip selects, active low
o_ready  out  1  can accept i_tx_valid
o_busy  out  1  CS asserted or shifting

Behaviour:
- Reset: o_rx=0, o_rx_valid=0, o_copi=0, o_sclk=0, o_cs_n=all 1, o_ready=0, o_busy=0. Config resets to div=1, mode 0, MSB first, cs_sel=0. State returns to IDLE at the next edge. Reset mid-transfer aborts immediately and the partial word is discarded.
- All outputs are registered. H = latched div+1.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: o_ready=1, o_busy=0, o_cs_n all 1, o_sclk=CPOL.
  - i_cfg_valid latches config in 1 cycle and stays in IDLE.
  - i_cfg_valid has priority over a simultaneous i_tx_valid; that tx is not accepted.
  - i_tx_valid latches i_tx and i_tx_last, then goes to SETUP.
- i_cfg_valid outside IDLE is ignored.
- SETUP (H cycles): o_cs_n[cs_sel]=0, o_ready=0, o_busy=1.
  - If CPHA=0, first data bit is driven on o_copi at SETUP entry.
  - cs_sel>=NUM_CS: no CS line asserts, but the transfer still runs.
- SHIFT: 2*DATA_WIDTH SCLK edges, one every H cycles; o_sclk toggles from CPOL.
  - CPHA=0: sample i_cipo on leading edges; drive next bit on trailing edges, except after the final edge.
  - CPHA=1: drive bit on leading edges; sample on trailing edges.
  - Bit order follows the latched lsb_first for both TX and RX.
  - o_rx_valid pulses 1 cycle, with o_rx updated, in the cycle after the final sample edge.
- After SHIFT: latched last=1 goes to HOLD; otherwise goes to GAP.
- HOLD (H cycles): CS stays low, o_sclk=CPOL. Then CS deasserts, o_copi=0, state returns to IDLE.
- GAP: CS held low, o_sclk=CPOL, o_ready=1, o_busy=1.
  - i_tx_valid latches the next word and goes to SETUP; CS stays low throughout.
  - No timeout.
- Latency: tx accepted at cycle T gives CS low at T+1, first SCLK edge at T+1+H, o_rx_valid at T+2+H*(2*DATA_WIDTH).
- o_rx_valid may coincide with o_ready=1 in GAP/IDLE entry. A tx_valid in that same cycle is accepted.

Test Plan:
- Mode 0, div=1, DATA_WIDTH=8, cs_sel=2, i_cipo looped to o_copi, tx 0xA5 last=1 -> o_cs_n=4'b1011 during transfer, SCLK period 4 cycles idle low, o_rx=0xA5 with one-cycle o_rx_valid at T+34, CS released 2 cycles later.
- Mode 3, div=0, i_cipo driven from a model returning 0x3C, tx 0x81 -> o_sclk idles high, COPI changes on falling edges, o_rx=0x3C, model captures 0x81.
- lsb_first=1, mode 1, tx 0x01 -> first COPI bit 1 then seven 0s, loopback o_rx=0x01.
- Burst of 3 words (last=0,0,1), tx_valid issued in cycle o_ready rises in GAP -> CS low continuously across all 3 words, three o_rx_valid pulses, CS high only after third HOLD.
- i_cfg_valid and i_tx_valid both high in IDLE with div=3 -> config latched, no transfer; next tx produces 8-cycle SCLK period.
- i_rst_n low at bit 4 of a transfer -> next edge o_cs_n all 1, o_sclk=0, o_rx_valid never pulses, o_ready=1 after release.

Source files
------------

// File: rtl/spi_controller_mc.sv
// ---------------------------------------------------------------------------
// spi_controller_mc
//
// Parametrised SPI controller with multiple active-low chip selects. It
// supports all four SPI modes, selectable bit order and multi-word bursts
// that keep chip select asserted between words. An integrated divider sets
// the SCLK half period to (div+1) i_clk cycles.
//
// Ports:
//   i_clk, i_rst_n    system clock, synchronous active-low reset
//   i_cfg_*           divider, mode {CPOL,CPHA}, bit order and CS index,
//                     latched on i_cfg_valid while idle
//   i_tx, i_tx_last   word to send and "release CS after this word" flag
//   i_tx_valid        start a word, accepted while o_ready=1
//   o_rx, o_rx_valid  received word and its one-cycle strobe
//   i_cipo, o_copi    serial data in / out
//   o_sclk, o_cs_n    SPI clock and chip selects
//   o_ready, o_busy   can accept a word / CS asserted or shifting
// ---------------------------------------------------------------------------
module spi_controller_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DIV_WIDTH-1:0]  i_cfg_div,
    input  logic [1:0]            i_cfg_mode,
    input  logic                  i_cfg_lsb_first,
    input  logic [CS_W-1:0]       i_cfg_cs_sel,
    input  logic                  i_cfg_valid,
    input  logic [DATA_WIDTH-1:0] i_tx,
    input  logic                  i_tx_last,
    input  logic                  i_tx_valid,
    output logic [DATA_WIDTH-1:0] o_rx,
    output logic                  o_rx_valid,
    input  logic                  i_cipo,
    output logic                  o_copi,
    output logic                  o_sclk,
    output logic [NUM_CS-1:0]     o_cs_n,
    output logic                  o_ready,
    output logic                  o_busy
);

    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_lsb;
    logic [CS_W-1:0]       r_cs_sel;
    logic [DATA_WIDTH-1:0] r_tx_sh;
    logic [DATA_WIDTH-1:0] r_rx_sh;
    logic                  r_last;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [EDGE_W-1:0]     r_edge;
    logic                  r_fin;

    logic                  w_tick;
    logic                  w_leading;
    logic                  w_final;
    logic                  w_accept;
    logic                  w_do_edge;
    logic [NUM_CS-1:0]     w_cs_n;

    // Bit at the head of the shift order, and the word after removing it.
    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
    endfunction

    // Received bits enter from the end opposite the one they are sent from,
    // so after DATA_WIDTH samples the word sits in natural order.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b, input logic lsb);
        return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
    endfunction

    // Out-of-range selects match no line, so the transfer runs with every
    // chip select left high.
    always_comb begin
        w_cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (r_cs_sel == CS_W'(i)) begin
                w_cs_n[i] = 1'b0;
            end
        end
    end

    // r_edge holds the number of SCLK edges already produced, so an even
    // count means the next edge is a leading one.
    assign w_tick    = (r_cnt == r_div);
    assign w_leading = ~r_edge[0];
    assign w_final   = (r_edge == EDGE_W'(2 * DATA_WIDTH - 1));
    assign w_accept  = i_tx_valid && o_ready &&
                       (((r_state == S_IDLE) && !i_cfg_valid) || (r_state == S_GAP));
    // SETUP expiry produces the first edge directly; the extra cycle after
    // the final edge (r_fin) presents the received word.
    assign w_do_edge = w_tick && ((r_state == S_SETUP) || ((r_state == S_SHIFT) && !r_fin));

    // Single state machine. The case handles per-state bookkeeping; word
    // acceptance and SCLK edge actions follow it and take precedence.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= DIV_WIDTH'(1);
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_cs_sel   <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
            r_edge     <= '0;
            r_fin      <= 1'b0;
            o_rx       <= '0;
            o_rx_valid <= 1'b0;
            o_copi     <= 1'b0;
            o_sclk     <= 1'b0;
            o_cs_n     <= '1;
            o_ready    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    o_cs_n  <= '1;
                    o_sclk  <= r_cpol;
                    if (i_cfg_valid) begin
                        r_div    <= i_cfg_div;
                        r_cpol   <= i_cfg_mode[1];
                        r_cpha   <= i_cfg_mode[0];
                        r_lsb    <= i_cfg_lsb_first;
                        r_cs_sel <= i_cfg_cs_sel;
                        o_sclk   <= i_cfg_mode[1];
                    end
                end

                S_SETUP: begin
                    if (w_tick) begin
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end

                S_SHIFT: begin
                    if (r_fin) begin
                        r_fin      <= 1'b0;
                        r_cnt      <= '0;
                        o_rx       <= r_rx_sh;
                        o_rx_valid <= 1'b1;
                        if (r_last) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_GAP;
                            o_ready <= 1'b1;
                        end
                    end else if (!w_tick) begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end

                S_HOLD: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        o_cs_n  <= '1;
                        o_copi  <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                        o_sclk  <= r_cpol;
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end

                S_GAP: begin
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // New word from IDLE or GAP. With CPHA=0 the first bit must be
            // on the line before the first (sampling) edge.
            if (w_accept) begin
                r_state <= S_SETUP;
                r_last  <= i_tx_last;
                r_cnt   <= '0;
                r_edge  <= '0;
                r_fin   <= 1'b0;
                o_ready <= 1'b0;
                o_busy  <= 1'b1;
                o_cs_n  <= w_cs_n;
                if (!r_cpha) begin
                    o_copi  <= head_bit(i_tx, r_lsb);
                    r_tx_sh <= shift_out(i_tx, r_lsb);
                end else begin
                    r_tx_sh <= i_tx;
                end
            end

            // SCLK edge: sample on leading edges when CPHA=0 and on
            // trailing edges when CPHA=1; drive on the other edge, except
            // that nothing is driven after the last edge.
            if (w_do_edge) begin
                o_sclk <= ~o_sclk;
                r_edge <= r_edge + EDGE_W'(1);
                r_cnt  <= '0;
                if (w_leading ^ r_cpha) begin
                    r_rx_sh <= shift_in(r_rx_sh, i_cipo, r_lsb);
                end else if (!w_final) begin
                    o_copi  <= head_bit(r_tx_sh, r_lsb);
                    r_tx_sh <= shift_out(r_tx_sh, r_lsb);
                end
                if (w_final) begin
                    r_fin <= 1'b1;
                end
            end
        end
    end

endmodule
